// File: rtl/icache_pkg.sv
// Shared types and derived geometry for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  localparam int unsigned BYTE_OFF_W = 2;
  localparam int unsigned WORD_W     = 32;

  function automatic int unsigned offset_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned index_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned mem_addr_w(input int unsigned addr_w, input int unsigned words);
    return addr_w - BYTE_OFF_W - offset_w(words);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned words,
                                        input int unsigned sets);
    return mem_addr_w(addr_w, words) - index_w(sets);
  endfunction

  function automatic int unsigned block_w(input int unsigned words);
    return WORD_W * words;
  endfunction

  // Select width that never collapses to zero for single-entry dimensions.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int unsigned addr_w, input int unsigned words,
                                      input int unsigned sets, input int unsigned ways);
    return is_pow2(words) && (words <= 16) && is_pow2(sets) &&
           ((ways == 1) || (ways == 2) || (ways == 4)) && (addr_w <= 32) &&
           (addr_w > BYTE_OFF_W + offset_w(words) + index_w(sets));
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and data block with fill write and bulk clear.
module icache_way #(
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [IDX_W-1:0]   rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_block,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_block
);

  localparam int unsigned Depth = 2 ** IDX_W;

  logic [Depth-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [Depth];
  logic [BLOCK_W-1:0] data_q [Depth];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_block;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_block = data_q[rd_index];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache with round-robin replacement and synchronous flush.
// Defining ICACHE_STATS_EN adds saturating HIT_COUNT / MISS_COUNT outputs.
module icache_sa import icache_pkg::*; #(
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned SETS            = 4,
  parameter int unsigned WAYS            = 2
) (
  input  logic                                           CLK,
  input  logic                                           RESET,
  input  logic [31:0]                                    PC,
  input  logic                                           FLUSH,
  output logic [31:0]                                    INSTRUCTION,
  output logic                                           BUSYWAIT,
`ifdef ICACHE_STATS_EN
  output logic [31:0]                                    HIT_COUNT,
  output logic [31:0]                                    MISS_COUNT,
`endif
  output logic                                           MEM_READ,
  output logic [mem_addr_w(ADDR_W, WORDS_PER_BLOCK)-1:0] MEM_ADDRESS,
  input  logic [block_w(WORDS_PER_BLOCK)-1:0]            MEM_READDATA,
  input  logic                                           MEM_BUSYWAIT
);

  localparam int unsigned OFFSET_W   = offset_w(WORDS_PER_BLOCK);
  localparam int unsigned INDEX_W    = index_w(SETS);
  localparam int unsigned MEM_ADDR_W = mem_addr_w(ADDR_W, WORDS_PER_BLOCK);
  localparam int unsigned TAG_W      = tag_w(ADDR_W, WORDS_PER_BLOCK, SETS);
  localparam int unsigned BLOCK_W    = block_w(WORDS_PER_BLOCK);
  localparam int unsigned OFF_SEL_W  = sel_w(WORDS_PER_BLOCK);
  localparam int unsigned IDX_SEL_W  = sel_w(SETS);
  localparam int unsigned PTR_W      = sel_w(WAYS);
  localparam int unsigned RR_DEPTH   = 2 ** IDX_SEL_W;

  localparam logic [ADDR_W-1:0]     OFF_MASK = ADDR_W'(WORDS_PER_BLOCK - 1);
  localparam logic [MEM_ADDR_W-1:0] IDX_MASK = MEM_ADDR_W'(SETS - 1);
  localparam logic [PTR_W-1:0]      PTR_MAX  = PTR_W'(WAYS - 1);

  if (!params_legal(ADDR_W, WORDS_PER_BLOCK, SETS, WAYS)) begin : g_bad_params
    $error("icache_sa: illegal ADDR_W/WORDS_PER_BLOCK/SETS/WAYS combination");
  end

  state_e                state_q;
  logic                  mem_read_q;
  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic [PTR_W-1:0]      victim_q;
  logic                  flush_pend_q;
  logic [PTR_W-1:0]      rr_q [RR_DEPTH];

  logic [ADDR_W-1:0]     pc_addr;
  logic [OFF_SEL_W-1:0]  offset;
  logic [MEM_ADDR_W-1:0] blk_addr;
  logic [IDX_SEL_W-1:0]  index;
  logic [TAG_W-1:0]      tag;
  logic [IDX_SEL_W-1:0]  fill_index;
  logic [TAG_W-1:0]      fill_tag;
  logic                  unused_pc;

  assign pc_addr    = PC[ADDR_W-1:0];
  assign unused_pc  = ^PC;
  assign offset     = OFF_SEL_W'((pc_addr >> BYTE_OFF_W) & OFF_MASK);
  assign blk_addr   = MEM_ADDR_W'(pc_addr >> (BYTE_OFF_W + OFFSET_W));
  assign index      = IDX_SEL_W'(blk_addr & IDX_MASK);
  assign tag        = TAG_W'(blk_addr >> INDEX_W);
  assign fill_index = IDX_SEL_W'(mem_addr_q & IDX_MASK);
  assign fill_tag   = TAG_W'(mem_addr_q >> INDEX_W);

  logic                  flush_now;
  logic                  flush_apply;
  logic                  fill_en;
  logic [WAYS-1:0]       way_valid;
  logic [WAYS-1:0]       way_hit;
  logic [WAYS-1:0]       way_we;
  logic [TAG_W-1:0]      way_tag   [WAYS];
  logic [BLOCK_W-1:0]    way_block [WAYS];

  assign flush_now   = FLUSH || flush_pend_q;
  assign flush_apply = (state_q == StIdle) && flush_now;
  assign fill_en     = (state_q == StFetch) && !MEM_BUSYWAIT;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .IDX_W   (IDX_SEL_W),
      .TAG_W   (TAG_W),
      .BLOCK_W (BLOCK_W)
    ) u_way (
      .clk      (CLK),
      .reset    (RESET),
      .clear    (flush_apply),
      .rd_index (index),
      .rd_valid (way_valid[w]),
      .rd_tag   (way_tag[w]),
      .rd_block (way_block[w]),
      .wr_en    (way_we[w]),
      .wr_index (fill_index),
      .wr_tag   (fill_tag),
      .wr_block (MEM_READDATA)
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == tag);
    assign way_we[w]  = fill_en && (victim_q == PTR_W'(w));
  end

  logic                  hit;
  logic [BLOCK_W-1:0]    hit_block;
  logic [31:0]           hit_word;
  logic [PTR_W-1:0]      victim;

  assign hit = |way_hit;

  always_comb begin
    hit_block = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_block = way_block[w];
    end
    hit_word = '0;
    for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
      if (OFF_SEL_W'(i) == offset) hit_word = hit_block[i*WORD_W +: WORD_W];
    end
  end

  // Descending scan so the lowest-index invalid way overrides the pointer.
  always_comb begin
    victim = rr_q[index];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim = PTR_W'(w);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      mem_read_q   <= 1'b0;
      mem_addr_q   <= '0;
      victim_q     <= '0;
      flush_pend_q <= 1'b0;
      for (int s = 0; s < RR_DEPTH; s++) rr_q[s] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_now) begin
            flush_pend_q <= 1'b0;
            for (int s = 0; s < RR_DEPTH; s++) rr_q[s] <= '0;
          end else if (!hit) begin
            state_q    <= StFetch;
            mem_read_q <= 1'b1;
            mem_addr_q <= blk_addr;
            victim_q   <= victim;
          end
        end
        StFetch: begin
          if (FLUSH) flush_pend_q <= 1'b1;
          if (!MEM_BUSYWAIT) begin
            state_q          <= StIdle;
            mem_read_q       <= 1'b0;
            rr_q[fill_index] <= (rr_q[fill_index] == PTR_MAX) ? '0 : rr_q[fill_index] + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = mem_addr_q;
  assign BUSYWAIT    = !RESET && ((state_q == StFetch) || (state_q == StIdle && !hit) || flush_now);
  assign INSTRUCTION = (!RESET && hit) ? hit_word : '0;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (state_q == StIdle && hit && !BUSYWAIT && hit_cnt_q != '1) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (state_q == StIdle && !hit && !flush_now && miss_cnt_q != '1) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_sa.sv
// Scoreboard bench: a 2-way default cache and a direct-mapped instance against a latency-5 memory.
module tb_icache_sa;

  localparam int LAT     = 5;
  localparam int TIMEOUT = 60;

  logic         clk;
  logic         rst;
  logic         sel_dm;
  int           n_checks;
  int           n_errors;
  int           exp_miss_a;
  logic [31:0]  exp_instr_q [$];
  logic [31:0]  exp_stall_q [$];

  logic [31:0]  pc_a, instr_a, pc_b, instr_b;
  logic         flush_a, busy_a, mem_read_a, mem_busy_a;
  logic         flush_b, busy_b, mem_read_b, mem_busy_b;
  logic [5:0]   mem_addr_a, mem_addr_b;
  logic [127:0] mem_data_a, mem_data_b;
  int           mem_cnt_a, mem_cnt_b;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_a, miss_a, hit_b, miss_b;
`endif

  icache_sa #(.ADDR_W(10), .WORDS_PER_BLOCK(4), .SETS(4), .WAYS(2)) u_dut (
    .CLK          (clk),
    .RESET        (rst),
    .PC           (pc_a),
    .FLUSH        (flush_a),
    .INSTRUCTION  (instr_a),
    .BUSYWAIT     (busy_a),
`ifdef ICACHE_STATS_EN
    .HIT_COUNT    (hit_a),
    .MISS_COUNT   (miss_a),
`endif
    .MEM_READ     (mem_read_a),
    .MEM_ADDRESS  (mem_addr_a),
    .MEM_READDATA (mem_data_a),
    .MEM_BUSYWAIT (mem_busy_a)
  );

  icache_sa #(.ADDR_W(10), .WORDS_PER_BLOCK(4), .SETS(8), .WAYS(1)) u_dm (
    .CLK          (clk),
    .RESET        (rst),
    .PC           (pc_b),
    .FLUSH        (flush_b),
    .INSTRUCTION  (instr_b),
    .BUSYWAIT     (busy_b),
`ifdef ICACHE_STATS_EN
    .HIT_COUNT    (hit_b),
    .MISS_COUNT   (miss_b),
`endif
    .MEM_READ     (mem_read_b),
    .MEM_ADDRESS  (mem_addr_b),
    .MEM_READDATA (mem_data_b),
    .MEM_BUSYWAIT (mem_busy_b)
  );

  // Memory word at word address wa holds 0xC0DE0000 + wa.
  function automatic logic [127:0] block_data(input logic [5:0] baddr);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = 32'hC0DE_0000 + {24'd0, baddr, 2'(w)};
    return b;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'hC0DE_0000 + {24'd0, pc[9:2]};
  endfunction

  assign mem_data_a = block_data(mem_addr_a);
  assign mem_data_b = block_data(mem_addr_b);
  assign mem_busy_a = mem_read_a && (mem_cnt_a != LAT - 1);
  assign mem_busy_b = mem_read_b && (mem_cnt_b != LAT - 1);

  always_ff @(posedge clk) begin
    mem_cnt_a <= mem_read_a ? mem_cnt_a + 1 : 0;
    mem_cnt_b <= mem_read_b ? mem_cnt_b + 1 : 0;
  end

  logic        busy_s, mem_read_s;
  logic [5:0]  mem_addr_s;
  logic [31:0] instr_s;
  assign busy_s     = sel_dm ? busy_b : busy_a;
  assign mem_read_s = sel_dm ? mem_read_b : mem_read_a;
  assign mem_addr_s = sel_dm ? mem_addr_b : mem_addr_a;
  assign instr_s    = sel_dm ? instr_b : instr_a;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge following the hit cycle.
  task automatic fetch(input logic [31:0] pc, input int stall_exp, input string tag,
                       output int stall);
    logic [31:0] addr_seen;
    addr_seen = 32'hFFFF_FFFF;
    exp_instr_q.push_back(word_at(pc));
    exp_stall_q.push_back(32'(stall_exp));
    if (sel_dm) pc_b = pc;
    else pc_a = pc;
    if (stall_exp > 0 && !sel_dm) exp_miss_a++;
    stall = 0;
    @(negedge clk);
    while (busy_s && stall < TIMEOUT) begin
      if (mem_read_s) addr_seen = {26'd0, mem_addr_s};
      stall++;
      @(negedge clk);
    end
    check_eq({tag, " stall"}, 32'(stall), exp_stall_q.pop_front());
    check_eq({tag, " instr"}, instr_s, exp_instr_q.pop_front());
    if (stall_exp > 0) check_eq({tag, " addr"}, addr_seen, {26'd0, pc[9:4]});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int misses;
    n_checks   = 0;
    n_errors   = 0;
    exp_miss_a = 0;
    sel_dm     = 1'b0;
    rst        = 1'b1;
    pc_a       = 32'h0;
    pc_b       = 32'h3FC;
    flush_a    = 1'b0;
    flush_b    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset busy", busy_a, 1'b0);
    check_eq("reset instr", instr_a, 32'h0);
    check_eq("reset mem_read", mem_read_a, 1'b0);
    check_eq("reset mem_addr", mem_addr_a, 6'h0);
    check_eq("reset dm mem_read", mem_read_b, 1'b0);
`ifdef ICACHE_STATS_EN
    check_eq("reset hit_count", hit_a, 32'h0);
    check_eq("reset miss_count", miss_a, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold miss then same-block hits.
    fetch(32'h000, LAT + 1, "cold 000", st);
    fetch(32'h004, 0, "hit 004", st);
    fetch(32'h008, 0, "hit 008", st);
    fetch(32'h00C, 0, "hit 00C", st);

    // Set 0 conflicts with round-robin replacement.
    fetch(32'h100, LAT + 1, "fill 100", st);
    fetch(32'h200, LAT + 1, "evict w0 200", st);
    fetch(32'h100, 0, "keep 100", st);
    fetch(32'h000, LAT + 1, "refill 000", st);
    fetch(32'h200, 0, "keep 200", st);
    fetch(32'h100, LAT + 1, "refill 100", st);

    // Flush while idle.
    flush_a = 1'b1;
    @(negedge clk);
    check_eq("idle flush busy", busy_a, 1'b1);
    @(posedge clk);
    #1;
    flush_a = 1'b0;
    fetch(32'h100, LAT + 1, "post flush 100", st);
    fetch(32'h000, LAT + 1, "post flush 000", st);
`ifdef ICACHE_STATS_EN
    check_eq("miss_count after flush", miss_a, 32'(exp_miss_a));
`endif

    // Flush during fetch: fill, one flush cycle, then a full refetch.
    exp_instr_q.push_back(word_at(32'h300));
    exp_stall_q.push_back(32'(2 * (LAT + 1) + 1));
    exp_miss_a += 2;
    pc_a = 32'h300;
    st = 0;
    @(negedge clk);
    while (busy_a && st < TIMEOUT) begin
      st++;
      flush_a = (st == 2);
      @(negedge clk);
    end
    flush_a = 1'b0;
    check_eq("fetch flush stall", 32'(st), exp_stall_q.pop_front());
    check_eq("fetch flush instr", instr_a, exp_instr_q.pop_front());
    @(posedge clk);
    #1;
    fetch(32'h000, LAT + 1, "after fetch flush 000", st);

    // Reset in the second fetch cycle abandons the fill.
    pc_a = 32'h040;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst in fetch busy", busy_a, 1'b0);
    check_eq("rst in fetch instr", instr_a, 32'h0);
    check_eq("rst in fetch read before", mem_read_a, 1'b1);
    @(posedge clk);
    #1;
    check_eq("rst in fetch read after", mem_read_a, 1'b0);
    check_eq("rst in fetch addr after", mem_addr_a, 6'h0);
`ifdef ICACHE_STATS_EN
    check_eq("rst miss_count", miss_a, 32'h0);
`endif
    exp_miss_a = 0;
    rst = 1'b0;
    fetch(32'h040, LAT + 1, "after rst 040", st);
    fetch(32'h000, LAT + 1, "after rst 000", st);
`ifdef ICACHE_STATS_EN
    check_eq("final miss_count", miss_a, 32'(exp_miss_a));
`endif

    // Direct-mapped instance over a 32-instruction loop.
    sel_dm = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      misses = 0;
      for (int i = 0; i < 32; i++) begin
        fetch(32'(i * 4), (pass == 0 && (i % 4) == 0) ? LAT + 1 : 0,
              $sformatf("dm p%0d i%0d", pass, i), st);
        if (st > 0) misses++;
      end
      check_eq($sformatf("dm pass%0d misses", pass), 32'(misses), (pass == 0) ? 32'd8 : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
